ls163: RTL

- Cycle-based model of the 74LS163 synchronous 4-bit binary counter with synchronous clear, for the TTL library of the Time Pilot '84 core.
- Sits directly upstream of the quad AND-gate model: counter outputs Q and RCO feed AND gates that decode horizontal/vertical timing and cascade enables.
- The chip's CLK pin is modelled as a clock-enable pulse on the single FPGA master clock, so chains of counters stay in one clock domain.

---
 rtl/ls163.sv | 49 ++++
 1 files changed

// File: rtl/ls163.sv
// ls163: cycle-based model of the 74LS163 synchronous 4-bit binary counter.
// The chip's CLK pin becomes a clock enable (cen) on the FPGA master clock,
// so cascaded counters all live in one clock domain. Clear, load and count
// are all synchronous; reset_n is an FPGA-only power-on reset.
module ls163 #(
    parameter logic [3:0] RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cen,
    input  logic       clr_n,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next count: clear beats load beats count; nothing moves without cen.
    always_comb begin
        count_d = count_q;
        if (cen) begin
            if (!clr_n) begin
                count_d = 4'h0;
            end else if (!load_n) begin
                count_d = d;
            end else if (enp && ent) begin
                count_d = count_q + 4'h1;
            end
        end
    end

    // Counter register; the asynchronous reset only sets the power-on value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign q   = count_q;
    assign rco = ent & (count_q == 4'hF);

endmodule
